// File: rtl/camera_scheduler.sv
// camera_scheduler: snapshots camera pose/config, issues one render-start pulse per frame,
// and recovers through a watchdog if the renderer never reports completion.
`default_nettype none

module camera_scheduler #(
  parameter int TIMEOUT_CYCLES = 2**26,
  parameter int FRAME_CNT_BITS = 16,
  parameter int FP_BITS        = 32,
  parameter int FP_FRAC        = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [3*FP_BITS-1:0]        pos_in,
  input  logic [3*FP_BITS-1:0]        dir_in,
  input  logic [6:0]                  cfg_in,
  input  logic                        force_refresh_in,
  input  logic                        render_done_in,
  output logic [3*FP_BITS-1:0]        pos_out,
  output logic [3*FP_BITS-1:0]        dir_out,
  output logic [6:0]                  cfg_out,
  output logic                        render_start_out,
  output logic                        busy_out,
  output logic [FRAME_CNT_BITS-1:0]   frame_count_out,
  output logic                        timeout_out
);

  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FP_BITS-1:0] FP_ZERO        = '0;
  localparam logic [FP_BITS-1:0] FP_ONE         = FP_BITS'(1) << FP_FRAC;
  localparam logic [FP_BITS-1:0] FP_THREE_HALFS = FP_ONE + (FP_ONE >> 1);
  localparam logic [FP_BITS-1:0] FP_NEG_3_2     = FP_ZERO - FP_THREE_HALFS;
  // Vectors are packed {x, y, z} with x in the most significant slot.
  localparam logic [3*FP_BITS-1:0] POS_RESET = {FP_ZERO, FP_ONE, FP_NEG_3_2};
  localparam logic [3*FP_BITS-1:0] DIR_RESET = {FP_ZERO, FP_ZERO, FP_ONE};
  localparam logic [WD_BITS-1:0]   WD_LAST   = WD_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               state, next_state;
  logic                 first_flag;
  logic [WD_BITS-1:0]   watchdog;
  logic                 pending;
  logic                 commit;
  logic                 count_done;
  logic                 fire;
  logic                 start_next;

  assign pending = ({pos_in, dir_in, cfg_in} != {pos_out, dir_out, cfg_out})
                   | force_refresh_in | first_flag;
  assign busy_out = (state != IDLE);

  always_comb begin
    next_state = state;
    commit     = 1'b0;
    count_done = 1'b0;
    fire       = 1'b0;
    start_next = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          commit     = 1'b1;
          next_state = START;
        end
      end
      START: begin
        start_next = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        // Completion wins over a watchdog expiry landing on the same cycle.
        if (render_done_in) begin
          count_done = 1'b1;
          next_state = IDLE;
        end else if (watchdog == WD_LAST) begin
          fire       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      first_flag       <= 1'b1;
      pos_out          <= POS_RESET;
      dir_out          <= DIR_RESET;
      cfg_out          <= '0;
      render_start_out <= 1'b0;
      frame_count_out  <= '0;
      timeout_out      <= 1'b0;
      watchdog         <= '0;
    end else begin
      state            <= next_state;
      render_start_out <= start_next;
      if (commit) begin
        pos_out    <= pos_in;
        dir_out    <= dir_in;
        cfg_out    <= cfg_in;
        first_flag <= 1'b0;
      end
      if (count_done) frame_count_out <= frame_count_out + 1'b1;
      if (fire)       timeout_out     <= 1'b1;
      if (state == START)
        watchdog <= '0;
      else if (state == RUN && !count_done && !fire)
        watchdog <= watchdog + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_camera_scheduler.sv
// Directed self-checking bench for camera_scheduler (TIMEOUT_CYCLES=16, FRAME_CNT_BITS=4).
`default_nettype none

module tb_camera_scheduler;

  localparam logic [95:0] RST_POS = {32'h0000_0000, 32'h0001_0000, 32'hFFFE_8000};
  localparam logic [95:0] RST_DIR = {32'h0000_0000, 32'h0000_0000, 32'h0001_0000};
  localparam logic [95:0] X_STEP  = {32'h0000_0200, 64'h0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [95:0] pos_in, dir_in;
  logic [6:0]  cfg_in;
  logic        force_refresh, done;
  logic [95:0] pos_out, dir_out;
  logic [6:0]  cfg_out;
  logic        start, busy, timeout;
  logic [3:0]  fc;

  int evaluated = 0;
  int failures  = 0;
  int pulse_cnt = 0;
  logic [3:0]  exp_fc;
  logic [95:0] pos1, pos2;

  camera_scheduler #(.TIMEOUT_CYCLES(16), .FRAME_CNT_BITS(4), .FP_BITS(32), .FP_FRAC(16)) dut (
    .clk_in(clk), .rst_in(rst), .pos_in(pos_in), .dir_in(dir_in), .cfg_in(cfg_in),
    .force_refresh_in(force_refresh), .render_done_in(done),
    .pos_out(pos_out), .dir_out(dir_out), .cfg_out(cfg_out),
    .render_start_out(start), .busy_out(busy), .frame_count_out(fc), .timeout_out(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start) pulse_cnt <= pulse_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pos"},   pos_out, RST_POS);
    check({tag, "_dir"},   dir_out, RST_DIR);
    check({tag, "_cfg"},   96'(cfg_out), 96'(0));
    check({tag, "_start"}, 96'(start), 96'(0));
    check({tag, "_busy"},  96'(busy), 96'(0));
    check({tag, "_fc"},    96'(fc), 96'(0));
    check({tag, "_tmo"},   96'(timeout), 96'(0));
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    pos_in = RST_POS; dir_in = RST_DIR; cfg_in = 7'h0;
    force_refresh = 1'b0; done = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // First frame after reset, inputs equal to reset snapshot.
    tick();
    check("first_busy", 96'(busy), 96'(1));
    check("first_nostart", 96'(start), 96'(0));
    tick();
    check("first_start", 96'(start), 96'(1));
    tick();
    check("first_start_low", 96'(start), 96'(0));
    repeat (8) tick();
    pulse_done();
    exp_fc = 4'd1;
    check("first_fc", 96'(fc), 96'(exp_fc));
    check("first_idle", 96'(busy), 96'(0));
    repeat (1000) tick();
    check("quiet_pulses", 96'(pulse_cnt), 96'(1));
    check("quiet_busy", 96'(busy), 96'(0));

    // Position change, then another change mid-RUN that must wait for done.
    pos1 = RST_POS + X_STEP;
    pos2 = pos1 + X_STEP;
    pos_in = pos1;
    tick();
    check("pos1_commit", pos_out, pos1);
    tick();
    check("pos1_start", 96'(start), 96'(1));
    pos_in = pos2;
    repeat (3) tick();
    check("pos_hold_run", pos_out, pos1);
    pulse_done();
    exp_fc = exp_fc + 4'd1;
    check("pos1_fc", 96'(fc), 96'(exp_fc));
    check("pos_hold_idle", pos_out, pos1);
    tick();
    check("pos2_commit", pos_out, pos2);
    tick();
    check("pos2_start", 96'(start), 96'(1));
    repeat (2) tick();
    pulse_done();
    exp_fc = exp_fc + 4'd1;
    check("pos2_fc", 96'(fc), 96'(exp_fc));

    // Continuous refresh, done 5 cycles after each start: start every 7 cycles, count wraps.
    force_refresh = 1'b1;
    tick();
    tick();
    check("refresh_start0", 96'(start), 96'(1));
    for (int i = 0; i < 14; i++) begin
      repeat (4) tick();
      if (i == 13) force_refresh = 1'b0;
      pulse_done();
      exp_fc = exp_fc + 4'd1;
      check("refresh_fc", 96'(fc), 96'(exp_fc));
      if (i != 13) begin
        tick();
        check("refresh_gap", 96'(start), 96'(0));
        tick();
        check("refresh_start", 96'(start), 96'(1));
      end
    end
    check("refresh_wrapped", 96'(fc), 96'(1));
    tick();
    check("refresh_stop", 96'(busy), 96'(0));

    // Watchdog: no done for 16 RUN cycles.
    cfg_in = 7'h55;
    tick();
    check("cfg_commit", 96'(cfg_out), 96'(7'h55));
    tick();
    check("tmo_start", 96'(start), 96'(1));
    cfg_in = 7'h2a;
    repeat (15) tick();
    check("tmo_not_yet", 96'(timeout), 96'(0));
    check("tmo_busy", 96'(busy), 96'(1));
    tick();
    check("tmo_fired", 96'(timeout), 96'(1));
    check("tmo_idle", 96'(busy), 96'(0));
    check("tmo_fc", 96'(fc), 96'(exp_fc));
    tick();
    check("tmo_recommit", 96'(cfg_out), 96'(7'h2a));
    tick();
    check("tmo_restart", 96'(start), 96'(1));
    check("tmo_sticky", 96'(timeout), 96'(1));
    repeat (2) tick();
    pulse_done();
    exp_fc = exp_fc + 4'd1;
    check("tmo_done_fc", 96'(fc), 96'(exp_fc));

    // Done ignored in IDLE and START.
    pulse_done();
    check("idle_done_fc", 96'(fc), 96'(exp_fc));
    check("idle_done_busy", 96'(busy), 96'(0));
    dir_in = RST_DIR + 96'h100;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("start_done_fc", 96'(fc), 96'(exp_fc));
    check("start_done_pulse", 96'(start), 96'(1));
    repeat (2) tick();
    check("start_done_busy", 96'(busy), 96'(1));

    // Asynchronous reset mid-RUN, then a first-frame commit with unchanged inputs.
    pos_in = RST_POS; dir_in = RST_DIR; cfg_in = 7'h0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_first_busy", 96'(busy), 96'(1));
    tick();
    check("rst_first_start", 96'(start), 96'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule

`default_nettype wire
